pixel_binarize_stream: RTL and testbench
========================================

PIXEL_BINARIZE_STREAM -- requirements
Module: pixel_binarize_stream

Interface
REQ-001 SHALL have parameter IN_W, default 10, per-channel input colour width (IN_W >= OUT_W).
REQ-002 SHALL have parameter OUT_W, default 8, grey output width.
REQ-003 SHALL have parameter IMG_COL, default 640, pixels per line.
REQ-004 SHALL have parameter IMG_ROW, default 480, lines per frame.
REQ-005 SHALL have port i_clk  in  1  single clock, all logic rising-edge.
REQ-006 SHALL have port i_rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port i_start  in  1  frame start request, level-sampled in IDLE.
REQ-008 SHALL have port i_thresh  in  OUT_W  binarize threshold.
REQ-009 SHALL have port i_invert  in  1  swap black/white polarity of o_bw.
REQ-010 SHALL have port o_read_request  out  1  pixel fetch request to the SDRAM reader.
REQ-011 SHALL have ports i_red, i_green, i_blue  in  IN_W each  pixel channels, qualified by i_valid.
REQ-012 SHALL have port i_valid  in  1  input pixel valid.
REQ-013 SHALL have port o_color  out  OUT_W  grey value.
REQ-014 SHALL have port o_bw  out  1  binary pixel (1 = black when i_invert=0).
REQ-015 SHALL have port o_valid  out  1  o_color/o_bw/markers valid.
REQ-016 SHALL have ports o_sol, o_eol, o_eof  out  1 each  start-of-line, end-of-line, end-of-frame markers, meaningful only with o_valid.
REQ-017 SHALL have ports o_busy, o_done  out  1 each  frame in progress; one-cycle completion pulse.

Function
REQ-018 FSM SHALL have states IDLE, RUN, DRAIN.
REQ-019 IDLE: i_start=1 SHALL latch i_thresh and i_invert, clear row/col counters, enter RUN.
REQ-020 RUN: o_read_request SHALL be 1 until the last pixel (row IMG_ROW-1, col IMG_COL-1) is accepted, then RUN→DRAIN.
REQ-021 A pixel SHALL be accepted only when i_valid=1 in RUN; i_valid in IDLE/DRAIN SHALL be ignored.
REQ-022 Col counter SHALL wrap IMG_COL-1→0 and increment row; row counter SHALL not wrap within a frame.
REQ-023 Grey SHALL be Y = (77·R' + 150·G' + 29·B') >> 8, where X' = X[IN_W-1 -: OUT_W]; intermediate sum width OUT_W+8 bits, no saturation needed (max 2^OUT_W-1).
REQ-024 o_bw SHALL be (Y < thresh_latched) XOR invert_latched.
REQ-025 Latency SHALL be exactly 2 cycles from accepted pixel to o_valid; one output per accepted pixel, order preserved, bubbles passed through.
REQ-026 o_sol SHALL mark col 0, o_eol col IMG_COL-1, o_eof the final pixel, all aligned with that pixel's o_valid.
REQ-027 DRAIN SHALL last until the pipeline is empty (2 cycles), then pulse o_done for one cycle and return to IDLE.
REQ-028 o_busy SHALL be 1 in RUN and DRAIN.
REQ-029 i_start during RUN/DRAIN SHALL be ignored; held i_start at o_done SHALL start the next frame the following cycle.
REQ-030 i_thresh/i_invert changes mid-frame SHALL not affect the current frame.

Reset
REQ-031 Assertion SHALL force IDLE, counters 0, pipeline valids 0, and all outputs 0 asynchronously, including mid-frame; no o_done on abort.
REQ-032 After deassertion the block SHALL remain IDLE until i_start.

Configuration
REQ-033 Macro FRAME_STATS_EN defined: SHALL add output o_black_count, width $clog2(IMG_ROW·IMG_COL+1), counting o_bw=1 outputs per frame, cleared at frame start, stable from o_done until the next frame start.
REQ-034 FRAME_STATS_EN undefined: port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-035 Package pixel_stream_pkg SHALL hold luma coefficients (77,150,29), fsm state enum, default IMG_ROW/IMG_COL constants.
REQ-036 Sub-module rgb_to_gray_pipe SHALL implement the 2-stage luma+threshold datapath; top holds FSM, counters, markers, stats.

Verification (IMG_COL=4, IMG_ROW=2, IN_W=10, OUT_W=8)
REQ-037 R=G=B=10'h3FF, thresh=128, invert=0 → o_color=255, o_bw=0, 2 cycles after i_valid.
REQ-038 R=10'h3FF,G=0,B=0 → o_color=76; thresh=77 → o_bw=1; invert=1 → o_bw=0.
REQ-039 8 pixels with gaps in i_valid → 8 o_valid, o_sol at outputs 0,4, o_eol at 3,7, o_eof at 7, o_done 2 cycles after last, o_read_request low after 8th acceptance.
REQ-040 i_rst_n low after 5 pixels → all outputs 0 immediately, no o_done; new i_start yields full 8-pixel frame.
REQ-041 FRAME_STATS_EN, 3 of 8 pixels below thresh → o_black_count=3 at o_done; next frame all white → 0.
REQ-042 i_thresh changed mid-frame and i_start pulsed in RUN → frame uses original thresh, no restart.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared constants and FSM state type for the pixel binarize stream.
// Luma weights sum to 256, so the >> 8 result never exceeds the input range.
package pixel_stream_pkg;

  localparam int unsigned LUMA_R     = 77;
  localparam int unsigned LUMA_G     = 150;
  localparam int unsigned LUMA_B     = 29;
  localparam int unsigned LUMA_SHIFT = 8;

  localparam int DEF_IMG_COL = 640;
  localparam int DEF_IMG_ROW = 480;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

endpackage

// File: rtl/rgb_to_gray_pipe.sv
// Two-stage datapath: stage 1 registers the luma, stage 2 registers grey + threshold.
// A sideband bus travels with each pixel so markers stay aligned with their data.
module rgb_to_gray_pipe
  import pixel_stream_pkg::*;
#(
  parameter int IN_W  = 10,
  parameter int OUT_W = 8,
  parameter int SB_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  red,
  input  logic [IN_W-1:0]  green,
  input  logic [IN_W-1:0]  blue,
  input  logic [SB_W-1:0]  in_side,
  input  logic [OUT_W-1:0] thresh,
  input  logic             invert,
  output logic             out_valid,
  output logic [OUT_W-1:0] color,
  output logic             bw,
  output logic [SB_W-1:0]  out_side
);

  localparam int SUM_W = OUT_W + 8;
  localparam int DROP  = IN_W - OUT_W;
  localparam logic [SUM_W-1:0] COEF_R = SUM_W'(LUMA_R);
  localparam logic [SUM_W-1:0] COEF_G = SUM_W'(LUMA_G);
  localparam logic [SUM_W-1:0] COEF_B = SUM_W'(LUMA_B);

  logic [OUT_W-1:0] r_t, g_t, b_t, grey;
  logic [SUM_W-1:0] sum;

  logic             s1_valid_reg;
  logic [OUT_W-1:0] s1_grey_reg;
  logic [SB_W-1:0]  s1_side_reg;

  // Keep only the top OUT_W bits of each channel before weighting.
  always_comb begin
    r_t  = OUT_W'(red   >> DROP);
    g_t  = OUT_W'(green >> DROP);
    b_t  = OUT_W'(blue  >> DROP);
    sum  = COEF_R * SUM_W'(r_t) + COEF_G * SUM_W'(g_t) + COEF_B * SUM_W'(b_t);
    grey = OUT_W'(sum >> LUMA_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_grey_reg  <= '0;
      s1_side_reg  <= '0;
      out_valid    <= 1'b0;
      color        <= '0;
      bw           <= 1'b0;
      out_side     <= '0;
    end else begin
      s1_valid_reg <= in_valid;
      s1_grey_reg  <= grey;
      s1_side_reg  <= in_valid ? in_side : '0;
      out_valid    <= s1_valid_reg;
      color        <= s1_grey_reg;
      bw           <= s1_valid_reg & ((s1_grey_reg < thresh) ^ invert);
      out_side     <= s1_side_reg;
    end
  end

endmodule

// File: rtl/pixel_binarize_stream.sv
// Frame sequencer around rgb_to_gray_pipe: FSM, row/col counters, line/frame markers.
// Define FRAME_STATS_EN to add o_black_count (black pixels in the last frame).
module pixel_binarize_stream
  import pixel_stream_pkg::*;
#(
  parameter int IN_W    = 10,
  parameter int OUT_W   = 8,
  parameter int IMG_COL = DEF_IMG_COL,
  parameter int IMG_ROW = DEF_IMG_ROW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [OUT_W-1:0] i_thresh,
  input  logic             i_invert,
  output logic             o_read_request,
  input  logic [IN_W-1:0]  i_red,
  input  logic [IN_W-1:0]  i_green,
  input  logic [IN_W-1:0]  i_blue,
  input  logic             i_valid,
  output logic [OUT_W-1:0] o_color,
  output logic             o_bw,
  output logic             o_valid,
  output logic             o_sol,
  output logic             o_eol,
  output logic             o_eof,
  output logic             o_busy,
  output logic             o_done
`ifdef FRAME_STATS_EN
  ,
  output logic [$clog2(IMG_ROW*IMG_COL+1)-1:0] o_black_count
`endif
);

  localparam int COL_W = (IMG_COL > 1) ? $clog2(IMG_COL) : 1;
  localparam int ROW_W = (IMG_ROW > 1) ? $clog2(IMG_ROW) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROW - 1);

  state_t           state_reg, state_next;
  logic             drain_cnt_reg, drain_cnt_next;
  logic             done_next;
  logic             start_frame;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;
  logic [OUT_W-1:0] thresh_reg;
  logic             invert_reg;
  logic             accept, last_pix;
  logic [2:0]       side_in, side_out;

  assign accept   = (state_reg == RUN) && i_valid;
  assign last_pix = (col_reg == COL_LAST) && (row_reg == ROW_LAST);

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    done_next      = 1'b0;
    start_frame    = 1'b0;
    o_read_request = 1'b0;
    o_busy         = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          start_frame = 1'b1;
          state_next  = RUN;
        end
      end
      RUN: begin
        o_read_request = 1'b1;
        o_busy         = 1'b1;
        if (accept && last_pix) begin
          state_next     = DRAIN;
          drain_cnt_next = 1'b0;
        end
      end
      DRAIN: begin
        // Two cycles empties both pipeline stages before signalling done.
        o_busy         = 1'b1;
        drain_cnt_next = 1'b1;
        if (drain_cnt_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      o_done        <= done_next;
    end
  end

  // The row counter is held on the final pixel so it never wraps inside a frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_reg    <= '0;
      row_reg    <= '0;
      thresh_reg <= '0;
      invert_reg <= 1'b0;
    end else if (start_frame) begin
      col_reg    <= '0;
      row_reg    <= '0;
      thresh_reg <= i_thresh;
      invert_reg <= i_invert;
    end else if (accept && !last_pix) begin
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  assign side_in = {col_reg == '0, col_reg == COL_LAST, last_pix};

  rgb_to_gray_pipe #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SB_W (3)
  ) u_pipe (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .in_valid (accept),
    .red      (i_red),
    .green    (i_green),
    .blue     (i_blue),
    .in_side  (side_in),
    .thresh   (thresh_reg),
    .invert   (invert_reg),
    .out_valid(o_valid),
    .color    (o_color),
    .bw       (o_bw),
    .out_side (side_out)
  );

  assign {o_sol, o_eol, o_eof} = side_out;

`ifdef FRAME_STATS_EN
  localparam int STAT_W = $clog2(IMG_ROW*IMG_COL+1);
  logic [STAT_W-1:0] black_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      black_cnt_reg <= '0;
    else if (start_frame)
      black_cnt_reg <= '0;
    else if (o_valid && o_bw)
      black_cnt_reg <= black_cnt_reg + 1'b1;
  end

  assign o_black_count = black_cnt_reg;
`endif

endmodule

// File: tb/tb_pixel_binarize_stream.sv
// Directed bench for pixel_binarize_stream on a 4x2 frame; stats checks need FRAME_STATS_EN.
module tb_pixel_binarize_stream;

  localparam int IN_W = 10, OUT_W = 8, IMG_COL = 4, IMG_ROW = 2, NPIX = 8;

  logic             clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_start = 1'b0;
  logic [OUT_W-1:0] i_thresh = '0;
  logic             i_invert = 1'b0;
  logic             o_read_request;
  logic [IN_W-1:0]  i_red = '0, i_green = '0, i_blue = '0;
  logic             i_valid = 1'b0;
  logic [OUT_W-1:0] o_color;
  logic             o_bw, o_valid, o_sol, o_eol, o_eof, o_busy, o_done;
`ifdef FRAME_STATS_EN
  logic [3:0]       black_count;
`endif

  pixel_binarize_stream #(
    .IN_W(IN_W), .OUT_W(OUT_W), .IMG_COL(IMG_COL), .IMG_ROW(IMG_ROW)
  ) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_thresh(i_thresh),
    .i_invert(i_invert), .o_read_request(o_read_request),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue), .i_valid(i_valid),
    .o_color(o_color), .o_bw(o_bw), .o_valid(o_valid),
    .o_sol(o_sol), .o_eol(o_eol), .o_eof(o_eof),
    .o_busy(o_busy), .o_done(o_done)
`ifdef FRAME_STATS_EN
    , .o_black_count(black_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: captures every valid output and every done pulse.
  logic [7:0] mon_color [256];
  logic       mon_bw [256], mon_sol [256], mon_eol [256], mon_eof [256];
  int         mon_cyc [256];
  int         n_out = 0, done_cnt = 0, done_cyc = 0;
  logic       done_busy = 1'b0, post_done_busy = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    if (o_valid) begin
      if (n_out < 256) begin
        mon_color[n_out] <= o_color;
        mon_bw[n_out]    <= o_bw;
        mon_sol[n_out]   <= o_sol;
        mon_eol[n_out]   <= o_eol;
        mon_eof[n_out]   <= o_eof;
        mon_cyc[n_out]   <= cyc;
      end
      n_out <= n_out + 1;
    end
    if (prev_done) post_done_busy <= o_busy;
    if (o_done) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      done_busy <= o_busy;
    end
    prev_done <= o_done;
  end

  // Pixel source and expected results for the frame being driven.
  logic [IN_W-1:0] px_r [NPIX], px_g [NPIX], px_b [NPIX];
  logic [7:0]      exp_col [NPIX];
  logic            exp_bw [NPIX];
  int              drv_cyc [NPIX];
  int              base_out, base_done;
  logic            rr_pre, rr_post, busy_post;
  bit              tmo;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Mixed colours; expected grey by hand, bw for thresh=128, invert=0.
  task automatic set_frame_a();
    logic [IN_W-1:0] r [NPIX] = '{10'h3FF, 10'h3FF, 10'h000, 10'h000, 10'h000, 10'h200, 10'h3FF, 10'h1FF};
    logic [IN_W-1:0] g [NPIX] = '{10'h3FF, 10'h000, 10'h000, 10'h3FF, 10'h000, 10'h200, 10'h3FF, 10'h1FF};
    logic [IN_W-1:0] b [NPIX] = '{10'h3FF, 10'h000, 10'h000, 10'h000, 10'h3FF, 10'h200, 10'h000, 10'h1FF};
    logic [7:0]      c [NPIX] = '{8'd255, 8'd76, 8'd0, 8'd149, 8'd28, 8'd128, 8'd226, 8'd127};
    logic            w [NPIX] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < NPIX; k++) begin
      px_r[k] = r[k]; px_g[k] = g[k]; px_b[k] = b[k];
      exp_col[k] = c[k]; exp_bw[k] = w[k];
    end
  endtask

  task automatic set_uniform(input logic [IN_W-1:0] r, input logic [IN_W-1:0] g,
                             input logic [IN_W-1:0] b, input logic [7:0] c, input logic w);
    for (int k = 0; k < NPIX; k++) begin
      px_r[k] = r; px_g[k] = g; px_b[k] = b;
      exp_col[k] = c; exp_bw[k] = w;
    end
  endtask

  task automatic drive_frame(input logic [7:0] th, input logic inv, input int gap,
                             input int npix, input bit mid_change, input bit hold_start);
    base_out  = n_out;
    base_done = done_cnt;
    i_thresh  = th;
    i_invert  = inv;
    i_start   = 1'b1;
    step();
    if (!hold_start) i_start = 1'b0;
    for (int k = 0; k < npix; k++) begin
      if (k % 3 == 1) repeat (gap) step();
      if (mid_change && k == 2) begin
        i_thresh = ~th;
        i_invert = ~inv;
        i_start  = 1'b1;
      end
      if (mid_change && k == 5) i_start = 1'b0;
      if (k == NPIX - 1) rr_pre = o_read_request;
      i_red = px_r[k]; i_green = px_g[k]; i_blue = px_b[k];
      i_valid = 1'b1;
      drv_cyc[k] = cyc;
      step();
      i_valid = 1'b0;
    end
    rr_post   = o_read_request;
    busy_post = o_busy;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done_cnt > base_done) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({o_read_request, o_color, o_bw, o_valid, o_sol, o_eol, o_eof, o_busy, o_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rr=%b color=%0d bw=%b valid=%b busy=%b done=%b, want all 0",
               o_read_request, o_color, o_bw, o_valid, o_busy, o_done);
    end
    i_rst_n = 1'b1;
    i_valid = 1'b1;
    i_red = 10'h3FF; i_green = 10'h3FF; i_blue = 10'h3FF;
    repeat (4) step();
    i_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_read_request !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b rr=%b, want 0 0", o_busy, o_read_request);
    end
    checks++;
    if (n_out !== 0 || done_cnt !== 0) begin
      errors++;
      $display("FAIL idle_valid_ignored: got outputs=%0d dones=%0d, want 0 0", n_out, done_cnt);
    end
    $display("test_reset: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_luma();
    set_frame_a();
    drive_frame(8'd128, 1'b0, 0, NPIX, 1'b0, 1'b0);
    wait_done(tmo);
    checks++;
    if (tmo || n_out - base_out !== NPIX) begin
      errors++;
      $display("FAIL luma_count: got %0d outputs timeout=%0b, want %0d", n_out - base_out, tmo, NPIX);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if (mon_color[base_out+k] !== exp_col[k] || mon_bw[base_out+k] !== exp_bw[k]) begin
        errors++;
        $display("FAIL luma_px%0d: got color=%0d bw=%b, want color=%0d bw=%b",
                 k, mon_color[base_out+k], mon_bw[base_out+k], exp_col[k], exp_bw[k]);
      end
      checks++;
      if (mon_cyc[base_out+k] - drv_cyc[k] !== 2) begin
        errors++;
        $display("FAIL latency_px%0d: got %0d cycles, want 2", k, mon_cyc[base_out+k] - drv_cyc[k]);
      end
    end
    $display("test_luma: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_gaps_markers();
    set_frame_a();
    drive_frame(8'd128, 1'b0, 2, NPIX, 1'b0, 1'b0);
    checks++;
    if (rr_pre !== 1'b1 || rr_post !== 1'b0 || busy_post !== 1'b1) begin
      errors++;
      $display("FAIL read_request: got before_last=%b after_last=%b busy=%b, want 1 0 1",
               rr_pre, rr_post, busy_post);
    end
    wait_done(tmo);
    checks++;
    if (tmo || n_out - base_out !== NPIX || done_cnt - base_done !== 1) begin
      errors++;
      $display("FAIL gaps_count: got outputs=%0d dones=%0d timeout=%0b, want 8 1 0",
               n_out - base_out, done_cnt - base_done, tmo);
    end
    for (int k = 0; k < NPIX; k++) begin
      checks++;
      if ({mon_sol[base_out+k], mon_eol[base_out+k], mon_eof[base_out+k]} !==
          {k % 4 == 0, k % 4 == 3, k == NPIX - 1}) begin
        errors++;
        $display("FAIL markers_px%0d: got sol=%b eol=%b eof=%b, want %b %b %b", k,
                 mon_sol[base_out+k], mon_eol[base_out+k], mon_eof[base_out+k],
                 k % 4 == 0, k % 4 == 3, k == NPIX - 1);
      end
      checks++;
      if (mon_cyc[base_out+k] - drv_cyc[k] !== 2 || mon_color[base_out+k] !== exp_col[k]) begin
        errors++;
        $display("FAIL gaps_px%0d: got latency=%0d color=%0d, want 2 %0d",
                 k, mon_cyc[base_out+k] - drv_cyc[k], mon_color[base_out+k], exp_col[k]);
      end
    end
    checks++;
    if (done_cyc - mon_cyc[base_out+NPIX-1] !== 1 || done_cyc - drv_cyc[NPIX-1] !== 3) begin
      errors++;
      $display("FAIL done_timing: got %0d cycles after last output, want 1",
               done_cyc - mon_cyc[base_out+NPIX-1]);
    end
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL back_idle: got busy=%b done=%b, want 0 0", o_busy, o_done);
    end
    $display("test_gaps_markers: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_thresh_invert();
    logic [7:0] th [3] = '{8'd77, 8'd77, 8'd76};
    logic       iv [3] = '{1'b0, 1'b1, 1'b0};
    logic       wb [3] = '{1'b1, 1'b0, 1'b0};
    for (int f = 0; f < 3; f++) begin
      set_uniform(10'h3FF, 10'h000, 10'h000, 8'd76, wb[f]);
      drive_frame(th[f], iv[f], 1, NPIX, 1'b0, 1'b0);
      wait_done(tmo);
      checks++;
      if (tmo || n_out - base_out !== NPIX) begin
        errors++;
        $display("FAIL thr_count_f%0d: got %0d outputs timeout=%0b, want 8", f, n_out - base_out, tmo);
      end
      for (int k = 0; k < NPIX; k += 3) begin
        checks++;
        if (mon_color[base_out+k] !== 8'd76 || mon_bw[base_out+k] !== wb[f]) begin
          errors++;
          $display("FAIL thr_f%0d_px%0d: got color=%0d bw=%b, want 76 %b (thresh=%0d invert=%b)",
                   f, k, mon_color[base_out+k], mon_bw[base_out+k], wb[f], th[f], iv[f]);
        end
      end
    end
    $display("test_thresh_invert: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_abort();
    int dones_before;
    set_frame_a();
    drive_frame(8'd128, 1'b0, 0, 5, 1'b0, 1'b0);
    checks++;
    if (o_valid !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_precond: got valid=%b busy=%b, want 1 1", o_valid, o_busy);
    end
    dones_before = done_cnt;
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_read_request, o_color, o_bw, o_valid, o_sol, o_eol, o_eof, o_busy, o_done} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got rr=%b color=%0d bw=%b valid=%b busy=%b, want all 0",
               o_read_request, o_color, o_bw, o_valid, o_busy);
    end
    repeat (2) step();
    i_rst_n = 1'b1;
    repeat (4) step();
    checks++;
    if (done_cnt !== dones_before || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: got dones=%0d busy=%b, want %0d 0", done_cnt, o_busy, dones_before);
    end
    drive_frame(8'd128, 1'b0, 0, NPIX, 1'b0, 1'b0);
    wait_done(tmo);
    checks++;
    if (tmo || n_out - base_out !== NPIX || mon_sol[base_out] !== 1'b1 || mon_eof[base_out+NPIX-1] !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart: got outputs=%0d sol0=%b eof7=%b timeout=%0b, want 8 1 1 0",
               n_out - base_out, mon_sol[base_out], mon_eof[base_out+NPIX-1], tmo);
    end
    $display("test_abort: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_mid_change();
    int sol_seen;
    set_frame_a();
    drive_frame(8'd128, 1'b0, 1, NPIX, 1'b1, 1'b0);
    wait_done(tmo);
    checks++;
    if (tmo || n_out - base_out !== NPIX || done_cnt - base_done !== 1) begin
      errors++;
      $display("FAIL mid_count: got outputs=%0d dones=%0d timeout=%0b, want 8 1 0",
               n_out - base_out, done_cnt - base_done, tmo);
    end
    sol_seen = 0;
    for (int k = 0; k < NPIX; k++) begin
      if (mon_sol[base_out+k]) sol_seen++;
      checks++;
      if (mon_bw[base_out+k] !== exp_bw[k]) begin
        errors++;
        $display("FAIL mid_bw_px%0d: got bw=%b, want %b", k, mon_bw[base_out+k], exp_bw[k]);
      end
    end
    checks++;
    if (sol_seen !== 2) begin
      errors++;
      $display("FAIL mid_no_restart: got %0d sol markers, want 2", sol_seen);
    end
    $display("test_mid_change: done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_back_to_back();
    set_frame_a();
    drive_frame(8'd128, 1'b0, 0, NPIX, 1'b0, 1'b1);
    wait_done(tmo);
    step();
    checks++;
    if (tmo || done_busy !== 1'b0 || post_done_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart: got busy_at_done=%b busy_after=%b timeout=%0b, want 0 1 0",
               done_busy, post_done_busy, tmo);
    end
    i_start = 1'b0;
    set_uniform(10'h3FF, 10'h3FF, 10'h3FF, 8'd255, 1'b0);
    drive_frame(8'd128, 1'b0, 0, NPIX, 1'b0, 1'b0);
    wait_done(tmo);
    checks++;
    if (tmo || n_out - base_out !== NPIX || mon_color[base_out] !== 8'd255 || mon_bw[base_out] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got outputs=%0d color0=%0d bw0=%b timeout=%0b, want 8 255 0 0",
               n_out - base_out, mon_color[base_out], mon_bw[base_out], tmo);
    end
    $display("test_back_to_back: done, checks=%0d errors=%0d", checks, errors);
  endtask

`ifdef FRAME_STATS_EN
  task automatic test_stats();
    set_frame_a();
    drive_frame(8'd100, 1'b0, 1, NPIX, 1'b0, 1'b0);
    wait_done(tmo);
    repeat (3) step();
    checks++;
    if (tmo || black_count !== 4'd3) begin
      errors++;
      $display("FAIL stats_three: got black_count=%0d timeout=%0b, want 3", black_count, tmo);
    end
    set_uniform(10'h3FF, 10'h3FF, 10'h3FF, 8'd255, 1'b0);
    drive_frame(8'd128, 1'b0, 0, NPIX, 1'b0, 1'b0);
    wait_done(tmo);
    checks++;
    if (tmo || black_count !== 4'd0) begin
      errors++;
      $display("FAIL stats_white: got black_count=%0d timeout=%0b, want 0", black_count, tmo);
    end
    $display("test_stats: done, checks=%0d errors=%0d", checks, errors);
  endtask
`endif

  initial begin
    test_reset();
    test_luma();
    test_gaps_markers();
    test_thresh_invert();
    test_abort();
    test_mid_change();
    test_back_to_back();
`ifdef FRAME_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
